// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-sink state enum.
// Also holds the one helper that classifies an RRESP code as an error.
package axi_pkg;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } xfer_state_t;

    function automatic logic is_err_resp(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// Synchronous FIFO with first-word fall-through output and occupancy level.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axi_sync_fifo #(
    parameter int WIDTH   = 33,
    parameter int LGDEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               full,
    output logic               empty,
    output logic [LGDEPTH:0]   level
);

    localparam int DEPTH = 1 << LGDEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LGDEPTH:0] wr_ptr_reg;
    logic [LGDEPTH:0] rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    assign level = wr_ptr_reg - rd_ptr_reg;
    assign full  = (level == (LGDEPTH+1)'(DEPTH));
    assign empty = (level == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Output is forced to zero when empty so nothing stale leaks out after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[LGDEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[LGDEPTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_master_rdata_sink.sv
// R-channel consumer: buffers read beats, streams them out with an end marker,
// and tracks per-transfer beat count to report done or error to the issuer.
module axi_master_rdata_sink
    import axi_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int LGFIFO  = 4,
    parameter int XFER_WD = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               xfer_start,
    input  logic [XFER_WD-1:0] xfer_beats,
    input  logic               rd_idle,
    input  logic               M_AXI_RVALID,
    input  logic [DATA_WD-1:0] M_AXI_RDATA,
    input  logic [1:0]         M_AXI_RRESP,
    input  logic               M_AXI_RLAST,
    output logic               M_AXI_RREADY,
    output logic               m_valid,
    output logic [DATA_WD-1:0] m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic [LGFIFO:0]    fifo_level,
    output logic               xfer_busy,
    output logic               xfer_done,
    output logic               xfer_err
);

    xfer_state_t        state_reg, state_next;
    logic [XFER_WD-1:0] remaining_reg, remaining_next;
    logic               err_reg, err_next;
    logic               done_reg, done_next;

    logic               rbeat;
    logic               final_beat;
    logic               fifo_wr;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_WD:0]   fifo_din;
    logic [DATA_WD:0]   fifo_dout;

    // Ready depends only on registered state and FIFO pointers, never on RVALID.
    assign M_AXI_RREADY = ((state_reg == STREAM) && !fifo_full) || (state_reg == FLUSH);
    assign rbeat        = M_AXI_RVALID && M_AXI_RREADY;
    assign final_beat   = (remaining_reg == XFER_WD'(1));
    assign fifo_din     = {final_beat, M_AXI_RDATA};

    assign m_valid   = !fifo_empty;
    assign m_last    = fifo_dout[DATA_WD];
    assign m_data    = fifo_dout[DATA_WD-1:0];
    assign xfer_busy = (state_reg != IDLE);
    assign xfer_done = done_reg;
    assign xfer_err  = err_reg;

    axi_sync_fifo #(
        .WIDTH   (DATA_WD + 1),
        .LGDEPTH (LGFIFO)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (m_valid && m_ready),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        err_next       = err_reg;
        done_next      = 1'b0;
        fifo_wr        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (xfer_start) begin
                    err_next = 1'b0;
                    if (xfer_beats != '0) begin
                        remaining_next = xfer_beats;
                        state_next     = STREAM;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (rbeat) begin
                    // An error response wins even on the final beat.
                    if (is_err_resp(M_AXI_RRESP)) begin
                        err_next   = 1'b1;
                        state_next = FLUSH;
                    end else begin
                        fifo_wr        = 1'b1;
                        remaining_next = remaining_reg - 1'b1;
                        if (final_beat) begin
                            state_next = DRAIN;
                            if (!M_AXI_RLAST) begin
                                err_next = 1'b1;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                if (rd_idle && !rbeat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                    done_next  = !err_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            err_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            err_reg       <= err_next;
            done_reg      <= done_next;
        end
    end

endmodule

// File: tb/tb_axi_master_rdata_sink.sv
// Scoreboard bench for axi_master_rdata_sink: the R driver queues expected
// stream beats, a negedge monitor pops and compares them as they are delivered.
module tb_axi_master_rdata_sink;

    localparam int DW = 32;
    localparam int LG = 4;
    localparam int XW = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          xfer_start = 1'b0;
    logic [XW-1:0] xfer_beats = '0;
    logic          rd_idle = 1'b1;
    logic          M_AXI_RVALID = 1'b0;
    logic [DW-1:0] M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = 2'b00;
    logic          M_AXI_RLAST = 1'b0;
    logic          M_AXI_RREADY;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic [LG:0]   fifo_level;
    logic          xfer_busy;
    logic          xfer_done;
    logic          xfer_err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int last_cnt = 0;
    int d0, l0;
    logic [DW:0] exp_q[$];
    logic [DW:0] exp_item;

    always #5 clk = ~clk;

    axi_master_rdata_sink #(.DATA_WD(DW), .LGFIFO(LG), .XFER_WD(XW)) dut (
        .clk(clk), .reset(reset), .xfer_start(xfer_start), .xfer_beats(xfer_beats),
        .rd_idle(rd_idle), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .fifo_level(fifo_level), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .xfer_err(xfer_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one line per delivered stream beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (xfer_done) done_cnt++;
            if (m_valid && m_ready) begin
                if (m_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_extra: got %0h expected no beat", {m_last, m_data});
                end else begin
                    exp_item = exp_q.pop_front();
                    $display("beat data=%08h last=%0b", m_data, m_last);
                    check("stream_beat", {m_last, m_data}, exp_item);
                end
            end
        end
    end

    task automatic start_xfer(input int n);
        @(posedge clk); #1;
        xfer_start = 1'b1;
        xfer_beats = XW'(n);
        @(posedge clk); #1;
        xfer_start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] resp, input logic last,
                             input bit push, input logic exp_last);
        int n;
        n = 0;
        if (push) exp_q.push_back({exp_last, d});
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = d;
        M_AXI_RRESP  = resp;
        M_AXI_RLAST  = last;
        @(negedge clk);
        while (!M_AXI_RREADY && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("rbeat_accept", M_AXI_RREADY, 1'b1);
        @(posedge clk); #1;
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (xfer_busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("idle_reached", xfer_busy, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rready"}, M_AXI_RREADY, 1'b0);
        check({tag, "_m_valid"}, m_valid, 1'b0);
        check({tag, "_m_data"}, m_data, '0);
        check({tag, "_m_last"}, m_last, 1'b0);
        check({tag, "_level"}, fifo_level, '0);
        check({tag, "_busy"}, xfer_busy, 1'b0);
        check({tag, "_done"}, xfer_done, 1'b0);
        check({tag, "_err"}, xfer_err, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b1;
        #20;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // RVALID in IDLE must not be accepted
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = 32'hdead_beef;
        repeat (3) @(negedge clk);
        check("idle_rready", M_AXI_RREADY, 1'b0);
        check("idle_level", fifo_level, 0);
        check("idle_busy", xfer_busy, 1'b0);
        @(posedge clk); #1;
        M_AXI_RVALID = 1'b0;

        // 4-beat clean transfer
        d0 = done_cnt; l0 = last_cnt;
        rd_idle = 1'b0;
        start_xfer(4);
        for (int i = 1; i <= 4; i++) send_beat(32'h1000 + i, 2'b00, i == 4, 1'b1, i == 4);
        rd_idle = 1'b1;
        wait_idle();
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_last_count", last_cnt - l0, 1);
        check("t1_err", xfer_err, 1'b0);
        $display("xfer beats=4 done");

        // 40 beats with backpressure: FIFO fills to 16 then RREADY drops
        d0 = done_cnt; l0 = last_cnt;
        m_ready = 1'b0;
        rd_idle = 1'b0;
        start_xfer(40);
        fork
            begin
                for (int i = 1; i <= 40; i++)
                    send_beat(32'h2000 + i, 2'b00, (i % 16 == 0) || (i == 40), 1'b1, i == 40);
            end
            begin
                repeat (30) @(negedge clk);
                check("t2_full_level", fifo_level, 16);
                check("t2_full_rready", M_AXI_RREADY, 1'b0);
                check("t2_head_data", m_data, 32'h2001);
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        rd_idle = 1'b1;
        wait_idle();
        check("t2_done_count", done_cnt - d0, 1);
        check("t2_last_count", last_cnt - l0, 1);
        $display("xfer beats=40 done");

        // SLVERR on beat 3: flush the rest, no done, no last
        d0 = done_cnt; l0 = last_cnt;
        rd_idle = 1'b0;
        start_xfer(8);
        send_beat(32'h3001, 2'b00, 1'b0, 1'b1, 1'b0);
        send_beat(32'h3002, 2'b00, 1'b0, 1'b1, 1'b0);
        send_beat(32'h3003, 2'b10, 1'b0, 1'b0, 1'b0);
        check("t3_err_set", xfer_err, 1'b1);
        for (int i = 4; i <= 8; i++) send_beat(32'h3000 + i, 2'b00, i == 8, 1'b0, 1'b0);
        check("t3_flush_rready", M_AXI_RREADY, 1'b1);
        check("t3_flush_busy", xfer_busy, 1'b1);
        rd_idle = 1'b1;
        wait_idle();
        check("t3_done_count", done_cnt - d0, 0);
        check("t3_last_count", last_cnt - l0, 0);
        check("t3_err_sticky", xfer_err, 1'b1);
        $display("xfer beats=8 slverr done");

        // Zero-length transfer: done one cycle after start
        d0 = done_cnt;
        @(posedge clk); #1;
        xfer_start = 1'b1;
        xfer_beats = '0;
        @(posedge clk); #1;
        xfer_start = 1'b0;
        check("t4_done_pulse", xfer_done, 1'b1);
        check("t4_busy", xfer_busy, 1'b0);
        check("t4_rready", M_AXI_RREADY, 1'b0);
        @(posedge clk); #1;
        check("t4_done_clear", xfer_done, 1'b0);
        check("t4_busy_after", xfer_busy, 1'b0);
        repeat (2) @(negedge clk);
        check("t4_done_count", done_cnt - d0, 1);
        $display("xfer beats=0 done");

        // Final beat missing RLAST: last still tagged, error, no done
        d0 = done_cnt; l0 = last_cnt;
        rd_idle = 1'b0;
        start_xfer(2);
        send_beat(32'h4001, 2'b00, 1'b0, 1'b1, 1'b0);
        send_beat(32'h4002, 2'b00, 1'b0, 1'b1, 1'b1);
        check("t5_err_set", xfer_err, 1'b1);
        rd_idle = 1'b1;
        wait_idle();
        check("t5_done_count", done_cnt - d0, 0);
        check("t5_last_count", last_cnt - l0, 1);
        check("t5_err_sticky", xfer_err, 1'b1);
        $display("xfer beats=2 no-rlast done");

        // Async reset mid-stream with 5 beats queued, then a clean 1-beat transfer
        m_ready = 1'b0;
        rd_idle = 1'b0;
        start_xfer(10);
        for (int i = 1; i <= 5; i++) send_beat(32'h5000 + i, 2'b00, 1'b0, 1'b0, 1'b0);
        check("t6_level5", fifo_level, 5);
        check("t6_busy", xfer_busy, 1'b1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        m_ready = 1'b1;
        d0 = done_cnt; l0 = last_cnt;
        start_xfer(1);
        send_beat(32'h6001, 2'b00, 1'b1, 1'b1, 1'b1);
        rd_idle = 1'b1;
        wait_idle();
        check("t6_done_count", done_cnt - d0, 1);
        check("t6_last_count", last_cnt - l0, 1);
        check("t6_err", xfer_err, 1'b0);
        $display("xfer beats=1 after reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
